inject_arb: RTL

INJECT_ARB -- requirements
Module: inject_arb

---
 rtl/inject_pkg.sv | 13 +
 rtl/inject_arb_rr_pick.sv | 32 +++
 rtl/inject_arb.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/inject_pkg.sv
// Shared definitions for the injecting round-robin burst arbiter.
package inject_pkg;

  localparam int N_DEF        = 4;
  localparam int W_DEF        = 8;
  localparam int MAXBURST_DEF = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

endpackage

// File: rtl/inject_arb_rr_pick.sv
// Circular first-set picker: finds the first asserted req at or after rr_ptr,
// wrapping from N-1 back to 0.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] rr_ptr,
  output logic [IW-1:0] index,
  output logic          found
);

  logic [IW:0] k;

  // Walk the requesters starting at rr_ptr; the first hit wins.
  always_comb begin
    index = '0;
    found = 1'b0;
    k     = '0;
    for (int i = 0; i < N; i++) begin
      k = {1'b0, rr_ptr} + (IW+1)'(i);
      if (k >= (IW+1)'(N)) begin
        k = k - (IW+1)'(N);
      end
      if (!found && req[k[IW-1:0]]) begin
        found = 1'b1;
        index = k[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/inject_arb.sv
// Round-robin burst arbiter with an OR-injection mask on the outgoing data.
// A grant lasts until a beat with o_last transfers or the granted requester
// drops req; either way one IDLE cycle follows before the next grant.
module inject_arb
  import inject_pkg::*;
#(
  parameter  int N        = N_DEF,
  parameter  int W        = W_DEF,
  parameter  int MAXBURST = MAXBURST_DEF,
  localparam int IW       = $clog2(N),
  localparam int CW       = $clog2(MAXBURST) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     req,
  input  logic [N*W-1:0]   data,
  input  logic [N-1:0]     last,
  input  logic [W-1:0]     inj_mask,
  input  logic             o_ready,
  output logic [N-1:0]     grant,
  output logic             o_valid,
  output logic [W-1:0]     o_data,
  output logic             o_last,
  output logic [IW-1:0]    o_src,
  output logic             state_dbg,
  output logic [CW-1:0]    count_dbg,
  output logic [IW-1:0]    rr_ptr_dbg
);

  // Handshake: a beat transfers on a rising edge where o_valid && o_ready.
  // o_valid follows req of the granted port; while o_ready is low the grant,
  // source, count and data source stay put, so o_data is stable as long as the
  // granted requester holds its data.

  state_t          state_q, state_d;
  logic [N-1:0]    grant_q;
  logic [IW-1:0]   src_q;
  logic [IW-1:0]   rr_ptr_q;
  logic [CW-1:0]   count_q;

  logic [W-1:0]    data_arr [N];
  logic [IW-1:0]   pick_idx;
  logic            pick_found;
  logic            cnt_at_max;
  logic            xfer;
  logic            abandon;
  logic            burst_end;
  logic [IW-1:0]   next_ptr;

  for (genvar g = 0; g < N; g++) begin : g_unpack
    assign data_arr[g] = data[g*W +: W];
  end

  rr_pick #(
    .N  (N),
    .IW (IW)
  ) u_rr_pick (
    .req    (req),
    .rr_ptr (rr_ptr_q),
    .index  (pick_idx),
    .found  (pick_found)
  );

  assign cnt_at_max = (count_q == CW'(MAXBURST - 1));
  assign xfer       = o_valid & o_ready;
  assign abandon    = (state_q == BURST) & ~req[src_q];
  assign burst_end  = abandon | (xfer & o_last);
  assign next_ptr   = (src_q == IW'(N - 1)) ? '0 : src_q + IW'(1);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: start a burst when anyone requests, leave it on last/abandon.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (pick_found) state_d = BURST;
      BURST:   if (burst_end)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Beat outputs, combinational from the granted port; quiet outside BURST.
  always_comb begin
    o_valid = 1'b0;
    o_data  = '0;
    o_last  = 1'b0;
    if (state_q == BURST) begin
      o_valid = req[src_q];
      if (o_valid) begin
        o_data = data_arr[src_q] | inj_mask;
        o_last = last[src_q] | cnt_at_max;
      end
    end
  end

  // Grant, source, beat count and round-robin pointer bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_q  <= '0;
      src_q    <= '0;
      count_q  <= '0;
      rr_ptr_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_found) begin
            grant_q <= {{(N-1){1'b0}}, 1'b1} << pick_idx;
            src_q   <= pick_idx;
            count_q <= '0;
          end
        end
        BURST: begin
          if (burst_end) begin
            grant_q  <= '0;
            count_q  <= '0;
            rr_ptr_q <= next_ptr;
          end else if (xfer) begin
            count_q <= count_q + CW'(1);
          end
        end
        default: begin
          grant_q <= '0;
          count_q <= '0;
        end
      endcase
    end
  end

  assign grant      = grant_q;
  assign o_src      = src_q;
  assign state_dbg  = (state_q == BURST);
  assign count_dbg  = count_q;
  assign rr_ptr_dbg = rr_ptr_q;

endmodule
